seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. Holds a 16-bit display value (4 hex nibbles), cycles one digit at a time, and drives the shared hex-to-segment decoder's 4-bit input plus the active-low digit-select lines. New values are double-buffered and take effect only at frame boundaries, so the display never tears.

## Interface
- `TICK_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `value` input 16: display value; nibble *i* is `value[4i+3:4i]` and belongs to digit *i*.
- `load` input 1: single-cycle strobe; captures `value` into the pending buffer.
- `pend` output 1: high while a loaded value is waiting for the next frame boundary.
- `frame` output 1: one-cycle pulse on the cycle the scan wraps from digit 3 to digit 0.
- `dec_in` output 4: nibble for the current digit, fed to the segment decoder.
- `digit_sel` output 4: active-low digit enables; bit *i* low means digit *i* is lit.

## Operation
- State:
  - prescaler `cnt` runs 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - digit index `dig` is 2 bits.
  - `shadow[15:0]` holds the displayed value.
  - `pbuf[15:0]` holds the pending value.
  - `pend` is a flag.
- When `cnt == TICK_DIV-1`:
  - `cnt` goes to 0.
  - `dig` goes to `dig+1` mod 4.
  - Otherwise `cnt` increments.
- Boundary cycle B is the cycle where `cnt == TICK_DIV-1` and `dig == 3`. `frame` is high in exactly that cycle.
- Outputs are combinational from registered state:
  - `digit_sel = ~(4'b0001 << dig)`.
  - `dec_in = shadow[4*dig +: 4]`.
  - Exactly one `digit_sel` bit is low, except when blanked (see Configuration).
- Load handling:
  - `load` outside B: `pbuf <= value`, `pend <= 1`. A repeated load overwrites `pbuf`; the last load wins.
  - B with `pend == 1` and no `load`: `shadow <= pbuf`, `pend <= 0`.
  - B with `load == 1`: `shadow <= value` (bypass, newest value wins), `pend <= 0`.
  - B with no pending value and no load: `shadow` is unchanged.
- Reset, asynchronous on `rst_n` low, from any state including mid-slot:
  - `cnt=0`, `dig=0`, `shadow=0`, `pbuf=0`, `pend=0`.
  - Hence `frame=0`, `dig_sel=4'b1110`, `dec_in=4'h0`.
  - Scan restarts at digit 0 on the first edge after `rst_n` rises.

## Timing
- Each digit is selected for exactly TICK_DIV cycles; a frame is 4·TICK_DIV cycles.
- `load` at cycle t, not in B: `pend` is high from t+1 until B+1. The new nibble for digit 0 appears on `dec_in` at B+1.
- `load` in B: `dec_in` shows `value[3:0]` at B+1; `pend` stays 0.
- Worst-case load-to-display latency is 4·TICK_DIV cycles.
- `frame` is high exactly one cycle per frame and is never high during reset.
- Counter wrap is modulo; no overflow state exists.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - For digit *i* > 0, `digit_sel` is forced to 4'b1111 during its slot when `shadow[15:4i]` is zero.
  - Digit 0 is never blanked.
  - `dec_in` is unchanged.
  - Slot timing and `frame` are unaffected.
- Macro undefined: all four digits are always lit, including leading zeros.

## Test plan
Run with TICK_DIV=4.
- **Reset:** hold `rst_n=0`, then release → `digit_sel=1110`, `dec_in=0`, `pend=0`. `digit_sel` steps 1101, 1011, 0111 every 4 cycles; `frame` pulses every 16 cycles.
- **Mid-frame load:** load 16'hA3C5 at dig=1 → `pend=1`; `dec_in` stays 0 until B. After B: `dec_in` sequence 5, 3, C, A; `pend=0`.
- **Overwrite:** load 16'h1111, then 16'h2222 within the same frame → only 2222 is ever displayed.
- **Load in B:** `pend` holds 16'h1234 and `load` carries 16'h9876 in B → B+1 shows `dec_in=6`, `pend=0`; 1234 is never displayed.
- **Reset mid-slot:** assert `rst_n` low at `cnt=2`, dig=2, with `pend=1` → all outputs at reset values immediately; the pending value is discarded.
- **Leading-zero blanking (`SEG_SCAN_LZB_EN`):** value 16'h0070 → digits 3 and 2 show `digit_sel=1111`, digit 1 is lit with 7, digit 0 is lit with 0. Value 16'h0000 → only digit 0 is lit.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    output logic        pend,
    output logic        frame,
    output logic [3:0]  dec_in,
    output logic [3:0]  digit_sel
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      pbuf_q, pbuf_d;
    logic             pend_q, pend_d;
    logic             last_c;
    logic             bnd_c;
    logic             blank_c;

    assign last_c = (cnt_q == CNT_MAX);
    assign bnd_c  = last_c && (dig_q == 2'd3);

    // Prescaler, digit advance and frame-boundary buffer transfer
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        dig_d    = dig_q;
        shadow_d = shadow_q;
        pbuf_d   = pbuf_q;
        pend_d   = pend_q;
        if (last_c) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end
        if (bnd_c) begin
            // A load landing on the boundary bypasses the pending buffer
            if (load) begin
                shadow_d = value;
            end else if (pend_q) begin
                shadow_d = pbuf_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pbuf_d = value;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            dig_q    <= 2'd0;
            shadow_q <= 16'h0000;
            pbuf_q   <= 16'h0000;
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            pbuf_q   <= pbuf_d;
            pend_q   <= pend_d;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // Blank digit i>0 when it and every more-significant nibble are zero
    always_comb begin
        blank_c = 1'b0;
        case (dig_q)
            2'd1:    blank_c = (shadow_q[15:4] == 12'h000);
            2'd2:    blank_c = (shadow_q[15:8] == 8'h00);
            2'd3:    blank_c = (shadow_q[15:12] == 4'h0);
            default: blank_c = 1'b0;
        endcase
    end
`else
    assign blank_c = 1'b0;
`endif

    assign pend      = pend_q;
    assign frame     = bnd_c;
    assign dec_in    = shadow_q[{dig_q, 2'b00} +: 4];
    assign digit_sel = blank_c ? 4'b1111 : ~(4'b0001 << dig_q);

endmodule
